reg_file_lp: RTL and testbench
==============================

Name: reg_file_lp

Overview:
- Parametrised next-generation register file for the 8-bit ISA datapath. Sits between decode and ALU, with writeback from both the ALU and data memory.
- Adds synchronous reset clearing, real clocked writes, and a writeback source select (ALU vs memory).
- Adds a one-deep pending-load tracker, because memory data arrives one cycle after the load issues.
- Port B returns either a register or a zero-extended immediate, selected by two_reg.

Parameters:
- W, 8, data width in bits.
- D, 4, address width; depth = 2**D registers.
- IMM_W, 3, immediate width, zero-extended to W on port B (IMM_W <= W).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high; clears all registers and the pending-load state.
- write_en  input  1  writeback request this cycle.
- read_mem  input  1  qualifies write_en: 1 = load (data arrives next cycle), 0 = ALU result.
- two_reg  input  1  1 = data_outB from registers[raddrB]; 0 = data_outB from zero-extended imm.
- raddrA  input  D  read address, port A.
- raddrB  input  D  read address, port B.
- imm  input  IMM_W  immediate operand.
- waddr  input  D  destination register.
- data_in_alu  input  W  ALU result, written the same cycle.
- data_in_mem  input  W  memory data, valid the cycle after a load issues.
- data_outA  output  W  combinational read A.
- data_outB  output  W  combinational read B or immediate.
- load_pending  output  1  registered; a load commit is in progress this cycle.
- stall  output  1  combinational; a read hits the pending load's destination and cannot be served.

Behaviour:
- Reset (synchronous, active-high):
  - All registers become 0; pend_valid = 0 and pend_addr = 0.
  - After reset: data_outA = 0; data_outB = 0 with two_reg = 1, or zext(imm) with two_reg = 0; load_pending = 0; stall = 0.
  - Reset asserted while pend_valid = 1 aborts the commit; data_in_mem that cycle is discarded.
  - Reset has priority over all writes.
- ALU write: write_en = 1 and read_mem = 0 → registers[waddr] <= data_in_alu at the edge; latency 1.
- Load issue, cycle N: write_en = 1 and read_mem = 1 → pend_valid <= 1, pend_addr <= waddr. No array write in cycle N.
- Load commit, cycle N+1 (pend_valid = 1):
  - registers[pend_addr] <= data_in_mem at the end of N+1.
  - pend_valid <= 0 unless a new load issues in N+1. Back-to-back loads commit on consecutive cycles.
- Simultaneous commit and ALU write:
  - Two internal write paths; both writes land.
  - Same address: the ALU write wins, as the younger instruction.
- Reads:
  - Combinational from the array; pre-edge values for any write in the current cycle.
  - Addresses wrap naturally within D bits. There is no out-of-range case.
- load_pending = pend_valid.
- stall = pend_valid && ((raddrA == pend_addr) || (two_reg && raddrB == pend_addr)), unless bypass is enabled (see Optional Feature).
  - While stalled, data outputs show the stale array value. The consumer must hold.
- A port B immediate never stalls and never bypasses.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined:
  - A read matching pend_addr while pend_valid = 1 returns data_in_mem; stall is tied to 0.
  - A read matching waddr of a same-cycle ALU write returns data_in_alu. The ALU match takes priority over the load match.
- Undefined:
  - No forwarding; stall behaves as stated in Behaviour.
  - Same-cycle ALU write-then-read returns the old value.

Decomposition:
- Package definitions:
  - REG_W = 8 and REG_D = 4 constants.
  - typedef logic [REG_W-1:0] reg_t.
  - typedef enum logic {OPB_IMM, OPB_REG} opb_sel_t, mapped from two_reg.
- Sub-module rf_read_port, instantiated twice:
  - Takes the address, the array word, the pending/ALU-write match info and the bypass data.
  - Returns the read value and its per-port stall contribution.
  - Keeps the bypass ifdef in one place.

Test Plan:
- Reset then read: reset 1 cycle; two_reg = 1, raddrA = 5, raddrB = 15 → data_outA = 0x00, data_outB = 0x00, load_pending = 0, stall = 0.
- ALU write/read: write r3 ← 0xA5 (alu); next cycle raddrA = 3 → 0xA5. Set two_reg = 0, imm = 3'b110 → data_outB = 0x06.
- Load without bypass: load r7 in cycle N; cycle N+1 data_in_mem = 0x3C, raddrA = 7 → stall = 1, load_pending = 1, data_outA = old. Cycle N+2 → r7 = 0x3C, stall = 0.
- Load with REGFILE_BYPASS_EN: same stimulus → cycle N+1 data_outA = 0x3C, stall = 0.
- Collision: load r2 in N; in N+1 data_in_mem = 0x11 and ALU writes r2 ← 0x22 → r2 = 0x22 after N+1. Repeat with ALU to r4 ← 0x22 → r2 = 0x11, r4 = 0x22.
- Reset mid-load: load r9 in N; reset in N+1 with data_in_mem = 0xFF → r9 = 0x00, load_pending = 0 in N+2. Back-to-back loads r1 then r2 → both commit correctly.

Source files
------------

// File: rtl/reg_file_lp_pkg.sv
// Shared definitions for the reg_file_lp register file: default geometry,
// the register word type, and the port-B operand select encoding.
package reg_file_lp_pkg;

    localparam int REG_W = 8;
    localparam int REG_D = 4;

    typedef logic [REG_W-1:0] reg_t;

    // Port B source: zero-extended immediate or register read.
    typedef enum logic {
        OPB_IMM = 1'b0,
        OPB_REG = 1'b1
    } opb_sel_t;

endpackage

// File: rtl/reg_file_lp_if.sv
// Decode/writeback bus of the reg_file_lp register file. The master drives
// addresses, write requests and writeback data; the slave (register file)
// returns the read data, the pending-load flag and the stall.
interface reg_file_lp_if
    import reg_file_lp_pkg::*;
#(
    parameter int W     = REG_W,
    parameter int D     = REG_D,
    parameter int IMM_W = 3
) ();

    logic             write_en;
    logic             read_mem;
    logic             two_reg;
    logic [D-1:0]     raddrA;
    logic [D-1:0]     raddrB;
    logic [IMM_W-1:0] imm;
    logic [D-1:0]     waddr;
    logic [W-1:0]     data_in_alu;
    logic [W-1:0]     data_in_mem;
    logic [W-1:0]     data_outA;
    logic [W-1:0]     data_outB;
    logic             load_pending;
    logic             stall;

    modport master (
        output write_en, read_mem, two_reg, raddrA, raddrB, imm, waddr,
               data_in_alu, data_in_mem,
        input  data_outA, data_outB, load_pending, stall
    );

    modport slave (
        input  write_en, read_mem, two_reg, raddrA, raddrB, imm, waddr,
               data_in_alu, data_in_mem,
        output data_outA, data_outB, load_pending, stall
    );

endinterface

// File: rtl/reg_file_lp_read_port.sv
// One combinational read port of reg_file_lp. Produces the read value and
// this port's stall contribution against the pending load.
// Optional forwarding is selected with the REGFILE_BYPASS_EN macro.
module rf_read_port #(
    parameter int W = 8,
    parameter int D = 4
) (
    input  logic [D-1:0] addr,
    input  logic [W-1:0] arr_word,
    input  logic         used,
    input  logic         pend_valid,
    input  logic [D-1:0] pend_addr,
    input  logic [W-1:0] data_in_mem,
    input  logic         alu_wr,
    input  logic [D-1:0] waddr,
    input  logic [W-1:0] data_in_alu,
    output logic [W-1:0] rdata,
    output logic         stall
);

`ifdef REGFILE_BYPASS_EN
    // Forward the youngest in-flight value: same-cycle ALU write first, then the committing load.
    always_comb begin
        rdata = arr_word;
        if (alu_wr && (waddr == addr)) begin
            rdata = data_in_alu;
        end else if (pend_valid && (pend_addr == addr)) begin
            rdata = data_in_mem;
        end
    end

    assign stall = 1'b0;

    // An immediate-selected port B simply ignores rdata, so 'used' has no role here.
    logic unused_sel;
    assign unused_sel = used;
`else
    // No forwarding: the array word is shown as-is and a hit on the pending load stalls.
    always_comb begin
        rdata = arr_word;
    end

    assign stall = used & pend_valid & (addr == pend_addr);

    logic unused_fwd;
    assign unused_fwd = ^{data_in_mem, alu_wr, waddr, data_in_alu};
`endif

endmodule

// File: rtl/reg_file_lp.sv
// reg_file_lp: 2**D x W register file with ALU and memory writeback, a
// one-deep pending-load tracker, and port B register/immediate select.
// Build option: define REGFILE_BYPASS_EN to forward in-flight writes
// to the read ports instead of stalling.
module reg_file_lp
    import reg_file_lp_pkg::*;
#(
    parameter int W     = REG_W,
    parameter int D     = REG_D,
    parameter int IMM_W = 3
) (
    input  logic          clk,
    input  logic          reset,
    reg_file_lp_if.slave  bus
);

    logic [W-1:0] regs [2**D];
    logic         pend_valid;
    logic [D-1:0] pend_addr;
    logic         alu_wr;
    logic         load_issue;
    opb_sel_t     opb_sel;
    logic [W-1:0] imm_ext;
    logic [W-1:0] rdata_a;
    logic [W-1:0] rdata_b;
    logic         stall_a;
    logic         stall_b;

    assign alu_wr     = bus.write_en & ~bus.read_mem;
    assign load_issue = bus.write_en &  bus.read_mem;
    assign opb_sel    = bus.two_reg ? OPB_REG : OPB_IMM;

    // Zero-extend the immediate to the data width.
    always_comb begin
        imm_ext              = '0;
        imm_ext[IMM_W-1:0]   = bus.imm;
    end

    // Array and load tracker; the ALU write is issued after the commit so it wins on the same address.
    always_ff @(posedge clk) begin
        if (reset) begin
            regs       <= '{default: '0};
            pend_valid <= 1'b0;
            pend_addr  <= '0;
        end else begin
            if (pend_valid) begin
                regs[pend_addr] <= bus.data_in_mem;
            end
            if (alu_wr) begin
                regs[bus.waddr] <= bus.data_in_alu;
            end
            pend_valid <= load_issue;
            if (load_issue) begin
                pend_addr <= bus.waddr;
            end
        end
    end

    rf_read_port #(.W(W), .D(D)) port_a (
        .addr        (bus.raddrA),
        .arr_word    (regs[bus.raddrA]),
        .used        (1'b1),
        .pend_valid  (pend_valid),
        .pend_addr   (pend_addr),
        .data_in_mem (bus.data_in_mem),
        .alu_wr      (alu_wr),
        .waddr       (bus.waddr),
        .data_in_alu (bus.data_in_alu),
        .rdata       (rdata_a),
        .stall       (stall_a)
    );

    rf_read_port #(.W(W), .D(D)) port_b (
        .addr        (bus.raddrB),
        .arr_word    (regs[bus.raddrB]),
        .used        (opb_sel == OPB_REG),
        .pend_valid  (pend_valid),
        .pend_addr   (pend_addr),
        .data_in_mem (bus.data_in_mem),
        .alu_wr      (alu_wr),
        .waddr       (bus.waddr),
        .data_in_alu (bus.data_in_alu),
        .rdata       (rdata_b),
        .stall       (stall_b)
    );

    assign bus.data_outA    = rdata_a;
    assign bus.data_outB    = (opb_sel == OPB_REG) ? rdata_b : imm_ext;
    assign bus.load_pending = pend_valid;
    assign bus.stall        = stall_a | stall_b;

endmodule

// File: tb/tb_reg_file_lp.sv
// Self-checking bench for reg_file_lp: directed vector table, hand-written
// load/reset sequences, then randomized traffic against a reference model.
module tb_reg_file_lp;
    import reg_file_lp_pkg::*;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    reg_file_lp_if bus ();

    reg_file_lp dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic       rst, we, rm, tr;
        logic [3:0] ra, rb, wa;
        logic [2:0] imm;
        logic [7:0] alu, mem;
        logic       chk;
        logic [7:0] ea, eb;
        logic       elp, est;
    } vec_t;

    // Reference model: register contents plus a queue of loads awaiting their data.
    reg_t m_regs [16];
    int   m_pend [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic reg_t m_read(input logic [3:0] a, input vec_t v);
        reg_t r;
        r = m_regs[a];
`ifdef REGFILE_BYPASS_EN
        if (v.we && !v.rm && v.wa == a) r = v.alu;
        else if (m_pend.size() > 0 && m_pend[0] == int'(a)) r = v.mem;
`endif
        return r;
    endfunction

    function automatic vec_t m_expect(input vec_t v);
        vec_t e;
        logic pend;
        e    = v;
        pend = (m_pend.size() > 0);
        e.ea  = m_read(v.ra, v);
        e.eb  = v.tr ? m_read(v.rb, v) : {5'b0, v.imm};
        e.elp = pend;
`ifdef REGFILE_BYPASS_EN
        e.est = 1'b0;
`else
        e.est = pend && (m_pend[0] == int'(v.ra) || (v.tr && m_pend[0] == int'(v.rb)));
`endif
        return e;
    endfunction

    task automatic m_update(input vec_t v);
        if (v.rst) begin
            foreach (m_regs[i]) m_regs[i] = '0;
            m_pend.delete();
        end else begin
            if (m_pend.size() > 0) m_regs[m_pend.pop_front()] = v.mem;
            if (v.we && !v.rm) m_regs[v.wa] = v.alu;
            if (v.we && v.rm) m_pend.push_back(int'(v.wa));
        end
    endtask

    // Drive one cycle, check outputs on the falling edge, advance the model on the rising edge.
    task automatic step(input string name, input vec_t v, input bit use_model);
        vec_t e;
        reset           = v.rst;
        bus.write_en    = v.we;
        bus.read_mem    = v.rm;
        bus.two_reg     = v.tr;
        bus.raddrA      = v.ra;
        bus.raddrB      = v.rb;
        bus.imm         = v.imm;
        bus.waddr       = v.wa;
        bus.data_in_alu = v.alu;
        bus.data_in_mem = v.mem;
        @(negedge clk);
        e = use_model ? m_expect(v) : v;
        if (use_model || v.chk) begin
            check({name, ".data_outA"},    32'(bus.data_outA),    32'(e.ea));
            check({name, ".data_outB"},    32'(bus.data_outB),    32'(e.eb));
            check({name, ".load_pending"}, 32'(bus.load_pending), 32'(e.elp));
            check({name, ".stall"},        32'(bus.stall),        32'(e.est));
        end
        @(posedge clk);
        m_update(v);
        #1;
    endtask

    function automatic vec_t idle();
        vec_t v;
        v = '{1'b0, 1'b0, 1'b0, 1'b1, 4'd0, 4'd0, 4'd0, 3'd0, 8'h00, 8'h00,
              1'b0, 8'h00, 8'h00, 1'b0, 1'b0};
        return v;
    endfunction

    vec_t vecs [13];

    initial begin
        vec_t v;

        //          rst we rm tr  ra  rb  wa  imm    alu    mem   chk  ea     eb     lp st
        vecs[0]  = '{1, 0, 0, 1,  0,  0,  0,  0,     8'h00, 8'h00, 0,  8'h00, 8'h00, 0, 0};
        vecs[1]  = '{0, 0, 0, 1,  5,  15, 0,  0,     8'h00, 8'h00, 1,  8'h00, 8'h00, 0, 0};
        vecs[2]  = '{0, 1, 0, 1,  5,  0,  3,  0,     8'hA5, 8'h00, 1,  8'h00, 8'h00, 0, 0};
        vecs[3]  = '{0, 0, 0, 0,  3,  0,  0,  3'b110, 8'h00, 8'h00, 1, 8'hA5, 8'h06, 0, 0};
        vecs[4]  = '{0, 1, 1, 0,  3,  0,  2,  3'b111, 8'h00, 8'h00, 1, 8'hA5, 8'h07, 0, 0};
        vecs[5]  = '{0, 1, 0, 0,  3,  0,  2,  0,     8'h22, 8'h11, 1,  8'hA5, 8'h00, 1, 0};
        vecs[6]  = '{0, 0, 0, 1,  2,  3,  0,  0,     8'h00, 8'h00, 1,  8'h22, 8'hA5, 0, 0};
        vecs[7]  = '{0, 1, 1, 1,  0,  0,  2,  0,     8'h00, 8'h00, 1,  8'h00, 8'h00, 0, 0};
        vecs[8]  = '{0, 1, 0, 1,  0,  1,  4,  0,     8'h22, 8'h11, 1,  8'h00, 8'h00, 1, 0};
        vecs[9]  = '{0, 0, 0, 1,  2,  4,  0,  0,     8'h00, 8'h00, 1,  8'h11, 8'h22, 0, 0};
        vecs[10] = '{0, 1, 1, 1,  0,  0,  5,  0,     8'h00, 8'h00, 1,  8'h00, 8'h00, 0, 0};
        vecs[11] = '{0, 0, 0, 0,  1,  5,  0,  3'b101, 8'h00, 8'h5A, 1, 8'h00, 8'h05, 1, 0};
        vecs[12] = '{0, 0, 0, 1,  5,  5,  0,  0,     8'h00, 8'h00, 1,  8'h5A, 8'h5A, 0, 0};

        foreach (m_regs[i]) m_regs[i] = '0;
        #1;
        for (int i = 0; i < 13; i++) begin
            step($sformatf("vec%0d", i), vecs[i], 1'b0);
        end

        // Load into r7 that already holds 0x77: stall (or forward) during the commit cycle.
        v = idle(); v.we = 1; v.wa = 7; v.alu = 8'h77;        step("ld7_pre", v, 1'b0);
        v = idle(); v.we = 1; v.rm = 1; v.wa = 7;              step("ld7_n", v, 1'b0);
        v = idle(); v.mem = 8'h3C; v.ra = 7; v.rb = 7; v.chk = 1; v.elp = 1;
`ifdef REGFILE_BYPASS_EN
        v.ea = 8'h3C; v.eb = 8'h3C; v.est = 0;
`else
        v.ea = 8'h77; v.eb = 8'h77; v.est = 1;
`endif
        step("ld7_n1", v, 1'b0);
        v = idle(); v.ra = 7; v.rb = 7; v.chk = 1; v.ea = 8'h3C; v.eb = 8'h3C;
        step("ld7_n2", v, 1'b0);

        // Reset during the commit cycle discards the memory data.
        v = idle(); v.we = 1; v.rm = 1; v.wa = 9;              step("rst_n", v, 1'b0);
        v = idle(); v.rst = 1; v.mem = 8'hFF;                  step("rst_n1", v, 1'b0);
        v = idle(); v.ra = 9; v.rb = 9; v.chk = 1;             step("rst_n2", v, 1'b0);

        // Back-to-back loads r1 then r2 commit on consecutive cycles.
        v = idle(); v.we = 1; v.rm = 1; v.wa = 1;              step("b2b_n", v, 1'b0);
        v = idle(); v.we = 1; v.rm = 1; v.wa = 2; v.mem = 8'h61; v.tr = 0;
        v.chk = 1; v.elp = 1;                                  step("b2b_n1", v, 1'b0);
        v = idle(); v.mem = 8'h62; v.tr = 0; v.chk = 1; v.elp = 1;
        step("b2b_n2", v, 1'b0);
        v = idle(); v.ra = 1; v.rb = 2; v.chk = 1; v.ea = 8'h61; v.eb = 8'h62;
        step("b2b_n3", v, 1'b0);

        // Commit and ALU write to the same register in one cycle: ALU value lands.
        v = idle(); v.we = 1; v.rm = 1; v.wa = 3;              step("prio_n", v, 1'b0);
        v = idle(); v.we = 1; v.wa = 3; v.alu = 8'hC3; v.mem = 8'hD3; v.ra = 3; v.tr = 0;
        v.chk = 1; v.elp = 1;
`ifdef REGFILE_BYPASS_EN
        v.ea = 8'hC3; v.est = 0;
`else
        v.ea = 8'h00; v.est = 1;
`endif
        step("prio_n1", v, 1'b0);
        v = idle(); v.ra = 3; v.chk = 1; v.ea = 8'hC3; v.eb = 8'h00;
        step("prio_n2", v, 1'b0);

        // Randomized traffic; addresses biased to a small set to provoke hazards.
        for (int c = 0; c < 600; c++) begin
            v = idle();
            v.rst = ($urandom_range(0, 39) == 0);
            v.we  = $urandom_range(0, 1);
            v.rm  = $urandom_range(0, 1);
            v.tr  = $urandom_range(0, 1);
            if ($urandom_range(0, 1) == 1) begin
                v.ra = 4'($urandom_range(0, 3));
                v.rb = 4'($urandom_range(0, 3));
                v.wa = 4'($urandom_range(0, 3));
            end else begin
                v.ra = 4'($urandom_range(0, 15));
                v.rb = 4'($urandom_range(0, 15));
                v.wa = 4'($urandom_range(0, 15));
            end
            v.imm = 3'($urandom_range(0, 7));
            v.alu = 8'($urandom_range(0, 255));
            v.mem = 8'($urandom_range(0, 255));
            step("rand", v, 1'b1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
